// File: rtl/dec_scan_pkg.sv
// Shared definitions for the dec_scan decoder/scanner: FSM encoding and
// default parameter values.
package dec_scan_pkg;

    localparam int N_DEFAULT     = 3;
    localparam int DWELL_DEFAULT = 2;
    localparam int DWELL_W       = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/dec_onehot.sv
// Combinational N-to-2**N one-hot decoder with enable.
// Bit 0 of the output vector (leftmost) selects code 0.
module dec_onehot
    import dec_scan_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic [N-1:0]    code_i,
    input  logic            en_i,
    output logic [0:2**N-1] onehot_o
);

    always_comb begin
        // NOTE: assign a default before any conditional write so no latch is inferred.
        onehot_o         = '0;
        onehot_o[code_i] = en_i;
    end

endmodule

// File: rtl/dec_scan.sv
// Registered one-hot decoder with a direct mode and a timed scan mode that
// walks every code for DWELL cycles, then pulses done.
module dec_scan
    import dec_scan_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int DWELL = DWELL_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            mode,
    input  logic [N-1:0]    w,
    input  logic            start,
    output logic [0:2**N-1] y,
    output logic [N-1:0]    code,
    output logic            busy,
    output logic            done
);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [N-1:0]       CODE_LAST  = '1;

    state_e               state_q, state_d;
    logic [N-1:0]         code_q, code_d;
    logic [DWELL_W-1:0]   dwell_q, dwell_d;
    logic [0:2**N-1]      y_q, y_d;
    logic                 y_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dwell_d = dwell_q;
        y_en_d  = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    if (!mode) begin
                        code_d = w;
                        y_en_d = 1'b1;
                    end else if (start) begin
                        state_d = SCAN;
                        code_d  = '0;
                        dwell_d = '0;
                        y_en_d  = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end

            SCAN: begin
                // Dropping en aborts silently; code keeps its last value.
                if (!en) begin
                    state_d = IDLE;
                    dwell_d = '0;
                end else if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if (code_q == CODE_LAST) begin
                        state_d = IDLE;
                        code_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        code_d = code_q + N'(1);
                        y_en_d = 1'b1;
                        busy_d = 1'b1;
                    end
                end else begin
                    dwell_d = dwell_q + DWELL_W'(1);
                    y_en_d  = 1'b1;
                    busy_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // Decode the next code so y is registered alongside code.
    dec_onehot #(.N(N)) u_dec_onehot (
        .code_i   (code_d),
        .en_i     (y_en_d),
        .onehot_o (y_d)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= IDLE;
            code_q  <= '0;
            dwell_q <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dwell_q <= dwell_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign y    = y_q;
    assign code = code_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_dec_scan.sv
// Directed self-checking bench for dec_scan: default instance (N=3, DWELL=2)
// plus a second instance with N=2, DWELL=1.
module tb_dec_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, mode, start;
    logic [2:0] w;
    logic [0:7] y;
    logic [2:0] code;
    logic       busy, done;

    logic       en2, mode2, start2;
    logic [1:0] w2;
    logic [0:3] y2;
    logic [1:0] code2;
    logic       busy2, done2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dec_scan #(.N(3), .DWELL(2)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w), .start(start),
        .y(y), .code(code), .busy(busy), .done(done)
    );

    dec_scan #(.N(2), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .mode(mode2), .w(w2), .start(start2),
        .y(y2), .code(code2), .busy(busy2), .done(done2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; start = 1'b0; w = '0;
        en2 = 1'b0; mode2 = 1'b0; start2 = 1'b0; w2 = '0;
        step();
        step();
        check("rst_y", y, 8'h00);
        check("rst_code", code, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b0;

        // Direct sweep, disabled then enabled.
        for (int i = 0; i < 8; i++) begin
            w = 3'(i);
            step();
            check("dis_y", y, 8'h00);
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = 3'(i);
            step();
            check("dir_y", y, 8'h80 >> i);
            check("dir_code", code, i);
        end

        // Start with mode=0 is ignored: stays in direct decode.
        w = 3'd5; start = 1'b1;
        step();
        start = 1'b0;
        check("st_m0_y", y, 8'h04);
        check("st_m0_busy", busy, 1'b0);

        // mode=1 without start -> y=0.
        mode = 1'b1;
        step();
        check("idle_scan_y", y, 8'h00);

        // Full scan.
        start = 1'b1;
        step();
        start = 1'b0;
        w = 3'd6;
        check("scan_y0", y, 8'h80);
        check("scan_code0", code, 3'd0);
        check("scan_busy0", busy, 1'b1);
        for (int k = 1; k < 16; k++) begin
            if (k == 5) begin start = 1'b1; mode = 1'b0; end
            if (k == 6) begin start = 1'b0; mode = 1'b1; end
            step();
            check("scan_y", y, 8'h80 >> (k / 2));
            check("scan_code", code, k / 2);
            check("scan_busy", busy, 1'b1);
            check("scan_done", done, 1'b0);
        end
        step();
        check("end_done", done, 1'b1);
        check("end_busy", busy, 1'b0);
        check("end_y", y, 8'h00);
        check("end_code", code, 3'd0);
        step();
        check("post_done", done, 1'b0);
        check("post_y", y, 8'h00);

        // Abort at code 3.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        check("abort_pre_code", code, 3'd3);
        en = 1'b0;
        step();
        check("abort_y", y, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check("abort_nodone", done, 1'b0);
        end

        // Mid-scan reset at code 5.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 10; k++) step();
        check("mrst_pre_code", code, 3'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mrst_y", y, 8'h00);
        check("mrst_code", code, 3'd0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_done", done, 1'b0);
        for (int k = 0; k < 20; k++) begin
            step();
            check("mrst_nodone", done, 1'b0);
        end

        // Back-to-back: start held high on the done cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k < 16; k++) step();
        step();
        check("b2b_done1", done, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        check("b2b_y0", y, 8'h80);
        check("b2b_busy", busy, 1'b1);
        check("b2b_done_clr", done, 1'b0);
        for (int k = 1; k < 16; k++) step();
        check("b2b_last_y", y, 8'h01);
        step();
        check("b2b_done2", done, 1'b1);
        check("b2b_y_end", y, 8'h00);

        // N=2, DWELL=1 instance.
        en = 1'b0;
        en2 = 1'b1; mode2 = 1'b1; start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            check("p_y", y2, 4'b1000 >> k);
            check("p_busy", busy2, 1'b1);
            check("p_done", done2, 1'b0);
        end
        step();
        check("p_done5", done2, 1'b1);
        check("p_y5", y2, 4'b0000);
        step();
        check("p_done6", done2, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dec_scan.md
DEC_SCAN -- requirements
Module: dec_scan

Interface
REQ-001 Parameter N, default 3: select width; output width is 2**N.
REQ-002 Parameter DWELL, default 2: cycles each code is held in scan mode; legal range 1..255.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: en  input  1  global enable; 0 forces y to all-zero.
REQ-007 Port: mode  input  1  0 = direct decode, 1 = scan.
REQ-008 Port: w  input  N  code to decode in direct mode.
REQ-009 Port: start  input  1  single-cycle scan request.
REQ-010 Port: y  output  2**N  one-hot output, indexed [0:2**N-1]; y[i]=1 selects code i.
REQ-011 Port: code  output  N  code currently driven on y.
REQ-012 Port: busy  output  1  high while a scan is in progress.
REQ-013 Port: done  output  1  one-cycle pulse at scan completion.

Function
REQ-014 y, code, busy and done SHALL be registered; y SHALL be all-zero or exactly one-hot.
REQ-015 FSM states: IDLE, SCAN.
REQ-016 IDLE, en=1, mode=0: on the next edge, y = one-hot of w and code = w; latency is 1 cycle.
REQ-017 IDLE, en=0: on the next edge, y = 0 and code holds its last value.
REQ-018 IDLE, en=1, mode=1, start=0: y = 0.
REQ-019 IDLE, en=1, mode=1, start=1 -> SCAN: on the next edge, code=0, y[0]=1, busy=1, dwell counter=0.
REQ-020 SCAN: each code is held for exactly DWELL cycles, then code increments by 1.
REQ-021 SCAN, final code 2**N-1 after its DWELL cycles -> IDLE: on that edge y=0, busy=0, done=1 for one cycle; code wraps to 0.
REQ-022 Total scan duration from the first y[0]=1 cycle to the done cycle SHALL be DWELL*2**N cycles.
REQ-023 start, w and mode SHALL be ignored while in SCAN.
REQ-024 en=0 during SCAN -> abort to IDLE: on the next edge y=0, busy=0, and done stays 0.
REQ-025 start=1 in the same cycle done is asserted SHALL be honoured: the next edge re-enters SCAN at code 0.
REQ-026 start with mode=0 or en=0 SHALL be ignored.

Reset
REQ-027 When rst=1 at an edge: state=IDLE, y=0, code=0, busy=0, done=0, dwell counter=0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-scan; no done pulse follows a reset.

Structure
REQ-029 Shared package dec_scan_pkg SHALL hold the FSM state encoding and the default values for N and DWELL.
REQ-030 The combinational N-to-2**N decode SHALL be a sub-module dec_onehot (inputs: code, enable; output: one-hot), instantiated once.
REQ-031 The dwell counter width SHALL be 8 bits; the code counter width SHALL be N.

Verification
REQ-032 Directed scenarios, with N=3 and DWELL=2 unless stated; each line is stimulus -> required response.
- Direct sweep: en=0, w=0..7 -> y=00000000 throughout. Then en=1, mode=0, w=0..7 -> y=10000000, 01000000, ... 00000001, each one cycle after w changes.
- Full scan: en=1, mode=1, start pulse -> y walks 10000000 through 00000001, 2 cycles per code; busy high for 16 cycles; done pulses once; then y=0.
- Abort: en dropped when code=3 -> y=0 and busy=0 on the next edge; done never asserts.
- Mid-scan reset: rst=1 at code=5 -> y=0, code=0, busy=0; no done pulse.
- Back-to-back scan: start=1 on the done cycle -> y[0]=1 on the next edge; second scan completes.
- Parameter sweep: N=2, DWELL=1 scan -> y walks 1000, 0100, 0010, 0001 on consecutive cycles; done pulses on the 5th cycle.
